cmp_result_tracker: RTL and testbench

Downstream consumer of the 4-bit comparator. Samples the comparator's one-hot flags x (A>B), y (A==B) and z (A<B) under a valid strobe, keeping saturating per-outcome counts and a consecutive-equality streak. It asserts a lock indication after LOCK_N consecutive equal results and flags any non-one-hot flag pattern as a sticky error. Used for match detection and result statistics behind the comparator.

---
 rtl/cmp_result_tracker.sv | 124 ++++++++++++
 tb/tb_cmp_result_tracker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cmp_result_tracker.sv
// Tracks one-hot comparator flags: saturating per-outcome counts, equality streak,
// a LOCK state after LOCK_N consecutive equal results, and a sticky illegal-flag error.
module cmp_result_tracker #(
  parameter int CW     = 8,
  parameter int SW     = 4,
  parameter int LOCK_N = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          x,
  input  logic          y,
  input  logic          z,
  input  logic          clear,
  output logic [CW-1:0] gt_count,
  output logic [CW-1:0] eq_count,
  output logic [CW-1:0] lt_count,
  output logic [SW-1:0] streak,
  output logic [1:0]    last_result,
  output logic          lock,
  output logic          err,
  output logic          out_valid
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] LOCK  = 2'd2;

  logic [2:0]    hit;
  logic          accept;
  logic          legal;
  logic          take;
  logic          bad;

  logic [1:0]    state_reg, state_next;
  logic [SW-1:0] streak_reg, streak_next;
  logic [1:0]    last_reg, last_next;
  logic          err_reg, err_next;
  logic          lock_reg;
  logic          out_valid_reg;

  // Bit order matches counter index: 0 = gt, 1 = eq, 2 = lt.
  assign hit    = {z, y, x};
  assign accept = in_valid & ~clear;
  assign legal  = (hit == 3'b001) | (hit == 3'b010) | (hit == 3'b100);
  assign take   = accept & legal;
  assign bad    = accept & ~legal;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : cnt_gen
      logic [CW-1:0] cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (clear) begin
          cnt_reg <= '0;
        end else if (take && hit[gi] && (cnt_reg != {CW{1'b1}})) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    streak_next = streak_reg;
    last_next   = last_reg;
    err_next    = err_reg;
    if (clear) begin
      state_next  = IDLE;
      streak_next = '0;
      last_next   = 2'b00;
      err_next    = 1'b0;
    end else if (take) begin
      if (y) begin
        streak_next = (streak_reg == {SW{1'b1}}) ? streak_reg : streak_reg + 1'b1;
        last_next   = 2'b10;
        // Covers IDLE->LOCK directly when LOCK_N is 1.
        if ((state_reg == LOCK) || (streak_next == SW'(LOCK_N)))
          state_next = LOCK;
        else
          state_next = TRACK;
      end else begin
        streak_next = '0;
        last_next   = x ? 2'b01 : 2'b11;
        state_next  = TRACK;
      end
    end else if (bad) begin
      err_next    = 1'b1;
      streak_next = '0;
      if (state_reg == LOCK)
        state_next = TRACK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      streak_reg    <= '0;
      last_reg      <= 2'b00;
      err_reg       <= 1'b0;
      lock_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      streak_reg    <= streak_next;
      last_reg      <= last_next;
      err_reg       <= err_next;
      lock_reg      <= (state_next == LOCK);
      out_valid_reg <= take;
    end
  end

  assign gt_count    = cnt_gen[0].cnt_reg;
  assign eq_count    = cnt_gen[1].cnt_reg;
  assign lt_count    = cnt_gen[2].cnt_reg;
  assign streak      = streak_reg;
  assign last_result = last_reg;
  assign lock        = lock_reg;
  assign err         = err_reg;
  assign out_valid   = out_valid_reg;

endmodule

// File: tb/tb_cmp_result_tracker.sv
// Bench for cmp_result_tracker: vector table with a scoreboard on out_valid,
// plus hand sequences for saturation, clear-vs-sample and asynchronous reset.
module tb_cmp_result_tracker;

  localparam int CW     = 8;
  localparam int SW     = 4;
  localparam int LOCK_N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          x = 1'b0;
  logic          y = 1'b0;
  logic          z = 1'b0;
  logic          clear = 1'b0;
  logic [CW-1:0] gt_count, eq_count, lt_count;
  logic [SW-1:0] streak;
  logic [1:0]    last_result;
  logic          lock, err, out_valid;

  cmp_result_tracker #(.CW(CW), .SW(SW), .LOCK_N(LOCK_N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y), .z(z),
    .clear(clear), .gt_count(gt_count), .eq_count(eq_count), .lt_count(lt_count),
    .streak(streak), .last_result(last_result), .lock(lock), .err(err),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic iv, xx, yy, zz, clr;
    logic [CW-1:0] gt, eq, lt;
    logic [SW-1:0] st;
    logic [1:0] last;
    logic lk, er, ov;
  } vec_t;

  typedef struct {
    logic [CW-1:0] gt, eq, lt;
    logic [SW-1:0] st;
    logic [1:0] last;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic iv, xx, yy, zz, clr,
                              input int gt, eq, lt, st, input logic [1:0] last,
                              input logic lk, er, ov);
    vec_t v;
    v.iv = iv; v.xx = xx; v.yy = yy; v.zz = zz; v.clr = clr;
    v.gt = CW'(gt); v.eq = CW'(eq); v.lt = CW'(lt); v.st = SW'(st);
    v.last = last; v.lk = lk; v.er = er; v.ov = ov;
    return v;
  endfunction

  // Called at a negedge: drive, then wait one full cycle so outputs reflect the posedge.
  task automatic cycle(input logic iv, xx, yy, zz, clr);
    in_valid = iv; x = xx; y = yy; z = zz; clear = clr;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gt"}, 32'(gt_count), 0);
    chk({tag, "_eq"}, 32'(eq_count), 0);
    chk({tag, "_lt"}, 32'(lt_count), 0);
    chk({tag, "_streak"}, 32'(streak), 0);
    chk({tag, "_last"}, 32'(last_result), 0);
    chk({tag, "_lock"}, 32'(lock), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_ov"}, 32'(out_valid), 0);
  endtask

  initial begin
    exp_t e;
    logic lg;

    // in_valid, x, y, z, clear | gt eq lt streak last lock err out_valid
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 1, 2'b10, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 2'b01, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 1, 1, 0, 2'b11, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 2, 1, 1, 0, 2'b01, 0, 0, 1));
    tbl.push_back(mk(0, 1'bx, 1'bx, 1'bx, 0, 2, 1, 1, 0, 2'b01, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 2, 2, 1, 1, 2'b10, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 2, 3, 1, 2, 2'b10, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 2, 4, 1, 3, 2'b10, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 2, 5, 1, 4, 2'b10, 1, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 2, 6, 1, 5, 2'b10, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 3, 6, 1, 0, 2'b01, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 3, 7, 1, 1, 2'b10, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 3, 8, 1, 2, 2'b10, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 3, 9, 1, 3, 2'b10, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 3, 10, 1, 4, 2'b10, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 3, 10, 1, 0, 2'b10, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 3, 11, 1, 1, 2'b10, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3, 11, 1, 0, 2'b10, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 1, 2'b10, 0, 1, 1));

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      lg = ({tbl[i].xx, tbl[i].yy, tbl[i].zz} inside {3'b100, 3'b010, 3'b001});
      if (tbl[i].iv && !tbl[i].clr && lg) begin
        e.gt = tbl[i].gt; e.eq = tbl[i].eq; e.lt = tbl[i].lt;
        e.st = tbl[i].st; e.last = tbl[i].last;
        sb_q.push_back(e);
      end
      cycle(tbl[i].iv, tbl[i].xx, tbl[i].yy, tbl[i].zz, tbl[i].clr);
      $display("vec %0d: gt=%0d eq=%0d lt=%0d streak=%0d last=%b lock=%b err=%b ov=%b",
               i, gt_count, eq_count, lt_count, streak, last_result, lock, err, out_valid);
      chk($sformatf("v%0d_gt", i), 32'(gt_count), 32'(tbl[i].gt));
      chk($sformatf("v%0d_eq", i), 32'(eq_count), 32'(tbl[i].eq));
      chk($sformatf("v%0d_lt", i), 32'(lt_count), 32'(tbl[i].lt));
      chk($sformatf("v%0d_streak", i), 32'(streak), 32'(tbl[i].st));
      chk($sformatf("v%0d_last", i), 32'(last_result), 32'(tbl[i].last));
      chk($sformatf("v%0d_lock", i), 32'(lock), 32'(tbl[i].lk));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].er));
      chk($sformatf("v%0d_ov", i), 32'(out_valid), 32'(tbl[i].ov));
      if (out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk($sformatf("v%0d_sb_empty", i), 32'(sb_q.size()), 1);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("v%0d_sb_gt", i), 32'(gt_count), 32'(e.gt));
          chk($sformatf("v%0d_sb_eq", i), 32'(eq_count), 32'(e.eq));
          chk($sformatf("v%0d_sb_lt", i), 32'(lt_count), 32'(e.lt));
          chk($sformatf("v%0d_sb_streak", i), 32'(streak), 32'(e.st));
          chk($sformatf("v%0d_sb_last", i), 32'(last_result), 32'(e.last));
        end
      end
    end
    chk("sb_leftover", 32'(sb_q.size()), 0);

    // Saturation of gt_count at 2^CW-1
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 300; i++) begin
      cycle(1, 1, 0, 0, 0);
      if (i == 253) chk("sat_254", 32'(gt_count), 254);
      if (i == 254) chk("sat_255", 32'(gt_count), 255);
    end
    $display("sat: 300 gt samples gt=%0d ov=%b", gt_count, out_valid);
    chk("sat_hold", 32'(gt_count), 255);
    chk("sat_ov", 32'(out_valid), 1);
    chk("sat_streak", 32'(streak), 0);
    chk("sat_last", 32'(last_result), 1);

    // Clear wins over a simultaneous sample
    cycle(1, 0, 1, 0, 1);
    $display("clear+sample: gt=%0d eq=%0d ov=%b", gt_count, eq_count, out_valid);
    chk_zero("clr");
    cycle(0, 0, 0, 0, 0);
    chk_zero("clr_hold");

    // Asynchronous reset mid-streak with out_valid pending
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    in_valid = 1'b1; x = 1'b0; y = 1'b1; z = 1'b0; clear = 1'b0;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    chk("arst_pre_streak", 32'(streak), 3);
    chk("arst_pre_ov", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    $display("async reset: streak=%0d ov=%b eq=%0d", streak, out_valid, eq_count);
    chk_zero("arst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("arst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
